// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_unit_pkg;

  localparam int unsigned ADDR_W = 5;

  typedef logic [ADDR_W-1:0] regAddr_t;

  // ALU operand source selected by forwarding.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } forward_sel;

  // Controller state.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hazard_state;

  // The youngest in-flight writer wins: M has priority over W; x0 is never forwarded.
  function automatic forward_sel fwdSelect(
    input regAddr_t rs,
    input regAddr_t rdM,
    input logic     regWriteM,
    input regAddr_t rdW,
    input logic     regWriteW
  );
    forward_sel sel;
    sel = FWD_REG;
    if (regWriteM && (rdM != '0) && (rdM == rs)) begin
      sel = FWD_M;
    end else if (regWriteW && (rdW != '0) && (rdW == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the performance statistics.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  // Count qualified cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward control for the five-stage core, with memory-wait
// tracking, a timeout trap and stall/flush performance counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  regAddr_t             Rs1D_i,
  input  regAddr_t             Rs2D_i,
  input  regAddr_t             Rs1E_i,
  input  regAddr_t             Rs2E_i,
  input  regAddr_t             RdE_i,
  input  regAddr_t             RdM_i,
  input  regAddr_t             RdW_i,
  input  logic                 RegWriteE_i,
  input  logic                 RegWriteM_i,
  input  logic                 RegWriteW_i,
  input  logic                 ResultSrcE_i,
  input  logic                 PCSrcE_i,
  input  logic                 MemReqM_i,
  input  logic                 MemReadyM_i,
  output logic                 StallF_o,
  output logic                 StallD_o,
  output logic                 StallE_o,
  output logic                 StallM_o,
  output logic                 FlushD_o,
  output logic                 FlushE_o,
  output logic                 FlushW_o,
  output forward_sel           ForwardAE_o,
  output forward_sel           ForwardBE_o,
  output logic                 MemErr_o,
  output logic [CNT_WIDTH-1:0] StallCycles_o,
  output logic [CNT_WIDTH-1:0] FlushCount_o
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hazard_state       state;
  logic [WAIT_W-1:0] waitCnt;
  logic              memErr;
  logic              memBusy;
  logic              loadUse;

  // An outstanding data access that has not completed this cycle.
  assign memBusy = MemReqM_i && !MemReadyM_i && (state != HALT);

  // Load in E whose result is needed by the instruction in D.
  assign loadUse = ResultSrcE_i && RegWriteE_i && (RdE_i != '0) &&
                   ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  // Stall/flush/forward decode from the current state and stage inputs.
  always_comb begin
    StallF_o    = 1'b0;
    StallD_o    = 1'b0;
    StallE_o    = 1'b0;
    StallM_o    = 1'b0;
    FlushD_o    = 1'b0;
    FlushE_o    = 1'b0;
    FlushW_o    = 1'b0;
    ForwardAE_o = FWD_REG;
    ForwardBE_o = FWD_REG;
    if (rst) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
      FlushW_o = 1'b1;
    end else begin
      ForwardAE_o = fwdSelect(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
      ForwardBE_o = fwdSelect(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
      if ((state == HALT) || memBusy) begin
        // Freeze everything up to M and drain W with a bubble.
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        StallE_o = 1'b1;
        StallM_o = 1'b1;
        FlushW_o = 1'b1;
      end else if (PCSrcE_i) begin
        // Redirect squashes the wrong-path instructions; any load-use stall is moot.
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
      end else if (loadUse) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end
    end
  end

  // Memory-wait state machine with timeout trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memBusy) begin
            state   <= MEM_WAIT;
            waitCnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (!memBusy) begin
            state <= RUN;
          end else if ((waitCnt + WAIT_W'(1)) == WAIT_LAST) begin
            state  <= HALT;
            memErr <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign MemErr_o = memErr;

  // Cycles spent with fetch held.
  sat_counter #(.WIDTH(CNT_WIDTH)) uStallCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (StallF_o),
    .count_o (StallCycles_o)
  );

  // Cycles in which decode was flushed.
  sat_counter #(.WIDTH(CNT_WIDTH)) uFlushCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (FlushD_o),
    .count_o (FlushCount_o)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit against a cycle-level reference model.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 4;
  localparam int          SAT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  forward_sel fwdA, fwdB;
  logic [CW-1:0] stallCycles, flushCount;
  logic [6:0] ctl;

  int total = 0;
  int bad   = 0;

  // Reference model state: consecutive busy cycles, trap flag, counters.
  bit mHalt;
  bit mErr;
  int mRun;
  int mStall;
  int mFlush;

  hazard_unit #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
    .RegWriteE_i(RegWriteE), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE),
    .MemReqM_i(MemReqM), .MemReadyM_i(MemReadyM),
    .StallF_o(StallF), .StallD_o(StallD), .StallE_o(StallE), .StallM_o(StallM),
    .FlushD_o(FlushD), .FlushE_o(FlushE), .FlushW_o(FlushW),
    .ForwardAE_o(fwdA), .ForwardBE_o(fwdB),
    .MemErr_o(MemErr), .StallCycles_o(stallCycles), .FlushCount_o(flushCount)
  );

  always #5 clk = ~clk;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
  function automatic logic [6:0] expCtl();
    logic busy, lu;
    busy = MemReqM && !MemReadyM;
    lu   = ResultSrcE && RegWriteE && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    if (rst)               return 7'b0000_111;
    if (mHalt || busy)     return 7'b1111_001;
    if (PCSrcE)            return 7'b0000_110;
    if (lu)                return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  function automatic forward_sel expFwd(input logic [4:0] rs);
    if (rst) return FWD_REG;
    if (RegWriteM && RdM != 0 && RdM == rs) return FWD_M;
    if (RegWriteW && RdW != 0 && RdW == rs) return FWD_W;
    return FWD_REG;
  endfunction

  task automatic clearInputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask

  // Advance one clock, updating the model from the pre-edge inputs.
  task automatic tick();
    logic [6:0] e;
    e = expCtl();
    if (!mHalt) begin
      if (MemReqM && !MemReadyM) begin
        mRun++;
        if (mRun == TO) begin
          mHalt = 1'b1;
          mErr  = 1'b1;
        end
      end else begin
        mRun = 0;
      end
    end
    if (e[6] && mStall < SAT) mStall++;
    if (e[2] && mFlush < SAT) mFlush++;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    mHalt = 0; mErr = 0; mRun = 0; mStall = 0; mFlush = 0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1'b1;
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5; MemReqM = 1'b1; PCSrcE = 1'b1;
    #3;
    total++; if (ctl !== 7'b0000_111) begin bad++; $display("FAIL rst_ctl: got %b want %b", ctl, 7'b0000_111); end
    total++; if (fwdA !== FWD_REG) begin bad++; $display("FAIL rst_fwdA: got %0d want %0d", fwdA, FWD_REG); end
    total++; if (fwdB !== FWD_REG) begin bad++; $display("FAIL rst_fwdB: got %0d want %0d", fwdB, FWD_REG); end
    @(posedge clk); #1;
    total++; if (stallCycles !== 0 || flushCount !== 0) begin bad++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", stallCycles, flushCount); end
    total++; if (MemErr !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", MemErr); end
    clearInputs();
    doReset();
  endtask

  task automatic test_forwarding();
    clearInputs();
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
    #1;
    total++; if (fwdA !== FWD_M) begin bad++; $display("FAIL fwd_m: got %0d want %0d", fwdA, FWD_M); end
    RdM = 5'd0;
    #1;
    total++; if (fwdA !== FWD_W) begin bad++; $display("FAIL fwd_w: got %0d want %0d", fwdA, FWD_W); end
    RdW = 5'd0; Rs2E = 5'd0;
    #1;
    total++; if (fwdB !== FWD_REG) begin bad++; $display("FAIL fwd_x0: got %0d want %0d", fwdB, FWD_REG); end
    tick();
    for (int i = 0; i < 30; i++) begin
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdM  = 5'($urandom_range(0, 3)); RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      #1;
      total++; if (fwdA !== expFwd(Rs1E)) begin bad++; $display("FAIL fwd_rndA[%0d]: got %0d want %0d", i, fwdA, expFwd(Rs1E)); end
      total++; if (fwdB !== expFwd(Rs2E)) begin bad++; $display("FAIL fwd_rndB[%0d]: got %0d want %0d", i, fwdB, expFwd(Rs2E)); end
      tick();
    end
    clearInputs();
  endtask

  task automatic test_load_use();
    int s0;
    clearInputs();
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RdE = 5'd3; Rs2D = 5'd3; Rs1D = 5'd1;
    #1;
    s0 = mStall;
    total++; if (ctl !== 7'b1100_010) begin bad++; $display("FAIL lu_ctl: got %b want %b", ctl, 7'b1100_010); end
    tick();
    ResultSrcE = 1'b0; RegWriteE = 1'b0;
    #1;
    total++; if (ctl !== 7'b0000_000) begin bad++; $display("FAIL lu_release: got %b want %b", ctl, 7'b0000_000); end
    total++; if (int'(stallCycles) != s0 + 1) begin bad++; $display("FAIL lu_cnt: got %0d want %0d", stallCycles, s0 + 1); end
    clearInputs();
  endtask

  task automatic test_branch();
    int f0;
    clearInputs();
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
    #1;
    f0 = mFlush;
    total++; if (ctl !== 7'b0000_110) begin bad++; $display("FAIL br_ctl: got %b want %b", ctl, 7'b0000_110); end
    tick();
    total++; if (int'(flushCount) != f0 + 1) begin bad++; $display("FAIL br_cnt: got %0d want %0d", flushCount, f0 + 1); end
    clearInputs();
  endtask

  task automatic test_mem_wait();
    clearInputs();
    MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ctl !== 7'b1111_001) begin bad++; $display("FAIL mw_stall[%0d]: got %b want %b", i, ctl, 7'b1111_001); end
      tick();
    end
    MemReadyM = 1'b1;
    #1;
    total++; if (ctl !== 7'b0000_000) begin bad++; $display("FAIL mw_ready: got %b want %b", ctl, 7'b0000_000); end
    tick();
    total++; if (MemErr !== 1'b0) begin bad++; $display("FAIL mw_err: got %b want 0", MemErr); end
    total++; if (int'(stallCycles) != mStall) begin bad++; $display("FAIL mw_cnt: got %0d want %0d", stallCycles, mStall); end
    // Same-cycle ready: no stall, and a following short wait must not trap.
    tick();
    total++; if (ctl !== 7'b0000_000) begin bad++; $display("FAIL mw_sameready: got %b want %b", ctl, 7'b0000_000); end
    clearInputs();
    tick();
  endtask

  task automatic test_timeout();
    clearInputs();
    doReset();
    MemReqM = 1'b1;
    for (int i = 0; i < int'(TO); i++) begin
      #1;
      total++; if (ctl !== 7'b1111_001 || MemErr !== 1'b0) begin bad++; $display("FAIL to_wait[%0d]: got %b/%b want %b/0", i, ctl, MemErr, 7'b1111_001); end
      tick();
    end
    total++; if (MemErr !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", MemErr); end
    MemReqM = 1'b0; PCSrcE = 1'b1;
    #1;
    total++; if (ctl !== 7'b1111_001) begin bad++; $display("FAIL to_halt: got %b want %b", ctl, 7'b1111_001); end
    tick();
    tick();
    total++; if (ctl !== 7'b1111_001 || MemErr !== 1'b1) begin bad++; $display("FAIL to_hold: got %b/%b want %b/1", ctl, MemErr, 7'b1111_001); end
    total++; if (int'(stallCycles) != mStall) begin bad++; $display("FAIL to_cnt: got %0d want %0d", stallCycles, mStall); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (ctl !== 7'b0000_111) begin bad++; $display("FAIL to_rstctl: got %b want %b", ctl, 7'b0000_111); end
    total++; if (MemErr !== 1'b0 || stallCycles !== 0 || flushCount !== 0) begin bad++; $display("FAIL to_rstclr: got %b/%0d/%0d want 0/0/0", MemErr, stallCycles, flushCount); end
    mHalt = 0; mErr = 0; mRun = 0; mStall = 0; mFlush = 0;
    rst = 1'b0;
    PCSrcE = 1'b0;
    #1;
    total++; if (ctl !== 7'b0000_000) begin bad++; $display("FAIL to_run: got %b want %b", ctl, 7'b0000_000); end
    clearInputs();
    tick();
  endtask

  task automatic test_saturation();
    clearInputs();
    doReset();
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    for (int i = 0; i < 20; i++) tick();
    total++; if (stallCycles !== 4'd15) begin bad++; $display("FAIL sat_stall: got %0d want 15", stallCycles); end
    total++; if (int'(flushCount) != mFlush) begin bad++; $display("FAIL sat_flush: got %0d want %0d", flushCount, mFlush); end
    clearInputs();
    tick();
  endtask

  task automatic test_random();
    clearInputs();
    doReset();
    for (int i = 0; i < 300; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      ResultSrcE = 1'($urandom); PCSrcE = ($urandom_range(0, 7) == 0);
      MemReqM = ($urandom_range(0, 2) == 0); MemReadyM = 1'($urandom);
      #1;
      total++; if (ctl !== expCtl()) begin bad++; $display("FAIL rnd_ctl[%0d]: got %b want %b", i, ctl, expCtl()); end
      total++; if (fwdA !== expFwd(Rs1E) || fwdB !== expFwd(Rs2E)) begin bad++; $display("FAIL rnd_fwd[%0d]: got %0d/%0d want %0d/%0d", i, fwdA, fwdB, expFwd(Rs1E), expFwd(Rs2E)); end
      total++; if (int'(stallCycles) != mStall || int'(flushCount) != mFlush || MemErr !== mErr) begin bad++; $display("FAIL rnd_state[%0d]: got %0d/%0d/%b want %0d/%0d/%b", i, stallCycles, flushCount, MemErr, mStall, mFlush, mErr); end
      tick();
      if (mHalt && ($urandom_range(0, 3) == 0)) doReset();
    end
    clearInputs();
  endtask

  initial begin
    mHalt = 0; mErr = 0; mRun = 0; mStall = 0; mFlush = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
